// File: rtl/ext_bus_ctrl_if.sv
// Request/response bundle between the CPU/MMU requester and ext_bus_ctrl.
// The requester holds address/op/data steady until the ready pulse.
interface ext_bus_ctrl_if #(
    parameter int DATA_BYTES = 4
);
    logic [23:0]             address;
    logic                    read;
    logic                    write;
    logic [1:0]              byteCount;
    logic [8*DATA_BYTES-1:0] dataIn;
    logic [8*DATA_BYTES-1:0] dataOut;
    logic                    ready;
    logic                    err;
    logic                    busy;

    modport master (
        output address, read, write, byteCount, dataIn,
        input  dataOut, ready, err, busy
    );

    modport slave (
        input  address, read, write, byteCount, dataIn,
        output dataOut, ready, err, busy
    );
endinterface

// File: rtl/ext_bus_ctrl.sv
// Sequences word requests onto the multiplexed 8-bit io bus as per-byte
// latch / strobe / turnaround cycles with ROM/RAM chip selects.
module ext_bus_ctrl #(
    parameter int          DATA_BYTES   = 4,
    parameter int          ADDR_LATCHES = 2,
    parameter int          WAIT_STATES  = 2,
    parameter logic [23:0] ROM_LIMIT    = 24'h008000
) (
    input  logic                    clk,
    input  logic                    rst,
    ext_bus_ctrl_if.slave           bus,
    inout  wire  [7:0]              io,
    output logic [ADDR_LATCHES-1:0] addrLatch,
    output logic                    nRamCe,
    output logic                    nRamRd,
    output logic                    nRamWr,
    output logic                    nRomCe,
    output logic                    nRomRd
);
    localparam int         LSEL_W      = (ADDR_LATCHES > 1) ? $clog2(ADDR_LATCHES) : 1;
    localparam logic [1:0] MAX_IDX     = (DATA_BYTES >= 4) ? 2'd3 : 2'(DATA_BYTES - 1);
    localparam logic [7:0] LATCH_LAST  = 8'(2 * ADDR_LATCHES - 1);
    localparam logic [7:0] ACCESS_LAST = 8'(WAIT_STATES);

    typedef enum logic [2:0] {IDLE, LATCH, ACCESS, RECOVER, DONE} state_t;

    state_t                  stateReg, stateNext;
    logic [23:0]             byteAddr;
    logic [1:0]              lastIdx;
    logic [1:0]              byteIdx;
    logic [7:0]              phaseCnt;
    logic                    opWrite;
    logic                    isRom;
    logic                    errReg;
    logic [8*DATA_BYTES-1:0] dataReg;
    logic [8*DATA_BYTES-1:0] dataOutReg;
    logic [8*DATA_BYTES-1:0] rdPacked;
    logic [7:0]              rdByte    [DATA_BYTES];
    logic [7:0]              wrByte    [DATA_BYTES];
    logic [7:0]              latchByte [ADDR_LATCHES];
    logic [LSEL_W-1:0]       latchSel;
    logic                    ioOe;
    logic [7:0]              ioOut;
    logic                    reqSeen;
    logic                    reject;
    logic                    sampleNow;

    assign reqSeen   = bus.read | bus.write;
    assign reject    = (bus.read & bus.write) | (bus.write & (bus.address < ROM_LIMIT));
    // Each latch gets a strobe cycle and a hold cycle, so the latch index is phaseCnt/2.
    assign latchSel  = phaseCnt[LSEL_W:1];
    assign sampleNow = (stateReg == ACCESS) && (phaseCnt == ACCESS_LAST) && !opWrite;

    assign io          = ioOe ? ioOut : 8'hzz;
    assign bus.ready   = (stateReg == DONE);
    assign bus.err     = (stateReg == DONE) && errReg;
    assign bus.busy    = (stateReg != IDLE);
    assign bus.dataOut = dataOutReg;

    for (genvar gi = 0; gi < ADDR_LATCHES; gi++) begin : gLatch
        if (8 * gi + 8 <= 24) begin : gAddr
            assign latchByte[gi] = byteAddr[8*gi +: 8];
        end else begin : gPad
            assign latchByte[gi] = 8'h00;
        end
        assign addrLatch[gi] = (stateReg == LATCH) && (latchSel == LSEL_W'(gi)) && !phaseCnt[0];
    end

    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : gData
        assign wrByte[gi]          = dataReg[8*gi +: 8];
        assign rdPacked[8*gi +: 8] = rdByte[gi];

        // Cleared at accept so bytes beyond the transfer length read back as zero.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rdByte[gi] <= 8'h00;
            end else if (stateReg == IDLE && reqSeen) begin
                rdByte[gi] <= 8'h00;
            end else if ((gi < 4) && sampleNow && (byteIdx == 2'(gi))) begin
                rdByte[gi] <= io;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (reqSeen) stateNext = reject ? DONE : LATCH;
            LATCH:   if (phaseCnt == LATCH_LAST) stateNext = ACCESS;
            ACCESS:  if (phaseCnt == ACCESS_LAST) stateNext = RECOVER;
            RECOVER: stateNext = (byteIdx == lastIdx) ? DONE : LATCH;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ioOe   = 1'b0;
        ioOut  = 8'h00;
        nRamCe = 1'b1;
        nRamRd = 1'b1;
        nRamWr = 1'b1;
        nRomCe = 1'b1;
        nRomRd = 1'b1;
        case (stateReg)
            LATCH: begin
                ioOe  = 1'b1;
                ioOut = latchByte[latchSel];
            end
            ACCESS: begin
                if (isRom) begin
                    nRomCe = 1'b0;
                    nRomRd = opWrite;
                end else begin
                    nRamCe = 1'b0;
                    nRamRd = opWrite;
                    nRamWr = !opWrite;
                end
                if (opWrite) begin
                    ioOe  = 1'b1;
                    ioOut = wrByte[byteIdx];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteAddr   <= 24'h000000;
            lastIdx    <= 2'd0;
            byteIdx    <= 2'd0;
            phaseCnt   <= 8'd0;
            opWrite    <= 1'b0;
            isRom      <= 1'b0;
            errReg     <= 1'b0;
            dataReg    <= '0;
            dataOutReg <= '0;
        end else begin
            case (stateReg)
                IDLE: if (reqSeen) begin
                    byteAddr <= bus.address;
                    lastIdx  <= (bus.byteCount > MAX_IDX) ? MAX_IDX : bus.byteCount;
                    byteIdx  <= 2'd0;
                    phaseCnt <= 8'd0;
                    opWrite  <= bus.write;
                    isRom    <= (bus.address < ROM_LIMIT);
                    errReg   <= reject;
                    dataReg  <= bus.dataIn;
                end
                LATCH:  phaseCnt <= (phaseCnt == LATCH_LAST) ? 8'd0 : phaseCnt + 8'd1;
                ACCESS: phaseCnt <= (phaseCnt == ACCESS_LAST) ? 8'd0 : phaseCnt + 8'd1;
                RECOVER: begin
                    // Region stays fixed for the whole burst; only the address walks.
                    byteAddr <= byteAddr + 24'd1;
                    byteIdx  <= byteIdx + 2'd1;
                    if (byteIdx == lastIdx && !opWrite) dataOutReg <= rdPacked;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Randomised bench for ext_bus_ctrl: a bus-pin monitor plays external latches and
// memory, and each request is judged against timing/region/data rules computed here.
module tb_ext_bus_ctrl;
    localparam int          DB        = 4;
    localparam int          AL        = 2;
    localparam int          WS        = 2;
    localparam logic [23:0] ROM_LIMIT = 24'h008000;
    localparam int          T         = 2 * AL + WS + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ext_bus_ctrl_if #(.DATA_BYTES(DB)) bus ();

    wire  [7:0]    io;
    logic          tbOe  = 1'b0;
    logic [7:0]    tbVal = 8'h00;
    logic [AL-1:0] addrLatch;
    logic          nRamCe, nRamRd, nRamWr, nRomCe, nRomRd;

    assign io = tbOe ? tbVal : 8'hzz;

    ext_bus_ctrl #(
        .DATA_BYTES  (DB),
        .ADDR_LATCHES(AL),
        .WAIT_STATES (WS),
        .ROM_LIMIT   (ROM_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .io       (io),
        .addrLatch(addrLatch),
        .nRamCe   (nRamCe),
        .nRamRd   (nRamRd),
        .nRamWr   (nRamWr),
        .nRomCe   (nRomCe),
        .nRomRd   (nRomRd)
    );

    int          checks      = 0;
    int          failures    = 0;
    logic [31:0] expDataOut  = 32'h0;
    logic [7:0]  latchVal [AL];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Contents of the external memories as seen through the 16-bit latched address.
    function automatic logic [7:0] memByte(input logic rom, input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ (rom ? 8'h3C : 8'hC3);
    endfunction

    task automatic doTxn(input logic [23:0] addr, input logic rd, input logic wr,
                         input logic [1:0] cnt, input logic [31:0] data,
                         input int dropAt, input string name);
        int          nBytes      = int'(cnt) + 1;
        bit          rej         = (rd && wr) || (wr && (addr < ROM_LIMIT));
        bit          romRegion   = (addr < ROM_LIMIT);
        int          expLat      = rej ? 1 : 1 + nBytes * T;
        int          cyc         = 0;
        int          busyCyc     = 0;
        int          readyCyc    = 0;
        int          latchPulses = 0;
        int          ramCyc      = 0;
        int          romCyc      = 0;
        int          rdCyc       = 0;
        int          wrCyc       = 0;
        logic        errSeen     = 1'b0;
        logic        prevIdle    = 1'b1;
        logic [31:0] doutAtReady = 32'h0;
        logic [31:0] expRead     = 32'h0;
        logic [15:0] seenAddr[$];
        logic [7:0]  seenData[$];
        logic [15:0] a16;

        checkVal({name, "/busy_before"}, 32'(bus.busy), 32'd0);
        bus.address   = addr;
        bus.read      = rd;
        bus.write     = wr;
        bus.byteCount = cnt;
        bus.dataIn    = data;

        while (readyCyc == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == dropAt) begin
                bus.read  = 1'b0;
                bus.write = 1'b0;
            end
            busyCyc += int'(bus.busy);
            for (int i = 0; i < AL; i++) begin
                if (addrLatch[i]) begin
                    latchPulses++;
                    latchVal[i] = io;
                end
            end
            ramCyc += int'(!nRamCe);
            romCyc += int'(!nRomCe);
            rdCyc  += int'(!nRamRd || !nRomRd);
            wrCyc  += int'(!nRamWr);
            if ((!nRamCe || !nRomCe) && prevIdle) begin
                seenAddr.push_back({latchVal[1], latchVal[0]});
                if (!nRamWr) seenData.push_back(io);
            end
            prevIdle = nRamCe & nRomCe;
            tbVal = memByte(!nRomCe, {latchVal[1], latchVal[0]});
            tbOe  = !nRamRd || !nRomRd;
            if (bus.ready) begin
                readyCyc    = cyc;
                errSeen     = bus.err;
                doutAtReady = bus.dataOut;
            end
        end
        bus.read  = 1'b0;
        bus.write = 1'b0;
        tbOe      = 1'b0;

        checkVal({name, "/ready_cycle"}, 32'(readyCyc), 32'(expLat));
        checkVal({name, "/err"}, 32'(errSeen), 32'(rej));
        checkVal({name, "/busy_cycles"}, 32'(busyCyc), 32'(expLat));
        if (rej) begin
            checkVal({name, "/latch_pulses"}, 32'(latchPulses), 32'd0);
            checkVal({name, "/strobe_cycles"}, 32'(ramCyc + romCyc + rdCyc + wrCyc), 32'd0);
        end else begin
            checkVal({name, "/latch_pulses"}, 32'(latchPulses), 32'(nBytes * AL));
            checkVal({name, "/rom_ce_cycles"}, 32'(romCyc), romRegion ? 32'(nBytes * (WS + 1)) : 32'd0);
            checkVal({name, "/ram_ce_cycles"}, 32'(ramCyc), romRegion ? 32'd0 : 32'(nBytes * (WS + 1)));
            checkVal({name, "/rd_cycles"}, 32'(rdCyc), wr ? 32'd0 : 32'(nBytes * (WS + 1)));
            checkVal({name, "/wr_cycles"}, 32'(wrCyc), wr ? 32'(nBytes * (WS + 1)) : 32'd0);
            checkVal({name, "/byte_accesses"}, 32'(seenAddr.size()), 32'(nBytes));
            for (int k = 0; k < nBytes; k++) begin
                a16 = addr[15:0] + 16'(k);
                if (k < seenAddr.size())
                    checkVal($sformatf("%s/addr%0d", name, k), 32'(seenAddr[k]), 32'(a16));
                if (wr && k < seenData.size())
                    checkVal($sformatf("%s/wdata%0d", name, k), 32'(seenData[k]), 32'(data[8*k +: 8]));
                expRead[8*k +: 8] = memByte(romRegion, a16);
            end
            if (!wr) expDataOut = expRead;
        end
        checkVal({name, "/dataOut"}, doutAtReady, expDataOut);

        @(negedge clk);
        checkVal({name, "/ready_single"}, 32'(bus.ready), 32'd0);
        checkVal({name, "/dataOut_held"}, bus.dataOut, expDataOut);
        $display("txn %-14s addr=%06h rd=%0d wr=%0d bytes=%0d ready@t0+%0d err=%0d dataOut=%08h",
                 name, addr, rd, wr, nBytes, readyCyc, errSeen, bus.dataOut);
    endtask

    task automatic resetMidWrite();
        int cyc   = 0;
        int rdyCt = 0;
        int bsyCt = 0;
        bus.address   = 24'h009000;
        bus.read      = 1'b0;
        bus.write     = 1'b1;
        bus.byteCount = 2'd0;
        bus.dataIn    = 32'h0000005A;
        while (nRamWr && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkVal("rstmid/reached_access", 32'(nRamWr), 32'd0);
        #2 rst = 1'b0;
        #1;
        checkVal("rstmid/strobes", {27'd0, nRamCe, nRamRd, nRamWr, nRomCe, nRomRd}, 32'h1F);
        checkVal("rstmid/latches", 32'(addrLatch), 32'd0);
        checkVal("rstmid/busy", 32'(bus.busy), 32'd0);
        expDataOut = 32'h0;
        checkVal("rstmid/dataOut", bus.dataOut, expDataOut);
        bus.write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            rdyCt += int'(bus.ready);
            bsyCt += int'(bus.busy);
        end
        checkVal("rstmid/no_ready", 32'(rdyCt), 32'd0);
        checkVal("rstmid/no_busy", 32'(bsyCt), 32'd0);
        $display("txn %-14s write aborted by reset, ready pulses after release=%0d", "rst_mid_write", rdyCt);
    endtask

    initial begin
        logic [23:0] ra;
        logic        rr, rw;
        int          sel;
        for (int i = 0; i < AL; i++) latchVal[i] = 8'h00;
        bus.address   = 24'h0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.byteCount = 2'd0;
        bus.dataIn    = 32'h0;

        repeat (3) @(negedge clk);
        checkVal("reset/ready", 32'(bus.ready), 32'd0);
        checkVal("reset/err", 32'(bus.err), 32'd0);
        checkVal("reset/busy", 32'(bus.busy), 32'd0);
        checkVal("reset/strobes", {27'd0, nRamCe, nRamRd, nRamWr, nRomCe, nRomRd}, 32'h1F);
        checkVal("reset/latches", 32'(addrLatch), 32'd0);
        checkVal("reset/dataOut", bus.dataOut, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        doTxn(24'h009012, 1'b1, 1'b0, 2'd0, 32'h0,        999, "rd1_ram");
        doTxn(24'h0080FF, 1'b0, 1'b1, 2'd3, 32'hDDCCBBAA, 999, "wr4_cross");
        doTxn(24'h000100, 1'b0, 1'b1, 2'd0, 32'h11223344, 999, "wr_rom_rej");
        doTxn(24'h009000, 1'b1, 1'b1, 2'd1, 32'h0,        999, "rdwr_rej");
        doTxn(24'hFFFFFF, 1'b1, 1'b0, 2'd1, 32'h0,        999, "rd2_wrap");
        doTxn(24'h007FFE, 1'b1, 1'b0, 2'd3, 32'h0,        999, "rd4_rom_cross");
        doTxn(24'h001234, 1'b1, 1'b0, 2'd0, 32'h0,        2,   "rd_dropped");
        doTxn(24'h00A000, 1'b0, 1'b1, 2'd2, 32'h00C0FFEE, 5,   "wr3_dropped");
        resetMidWrite();
        doTxn(24'h123456, 1'b1, 1'b0, 2'd2, 32'h0,        999, "rd3_after_rst");

        for (int n = 0; n < 40; n++) begin
            ra  = ($urandom_range(0, 1) == 0) ? 24'($urandom) : (ROM_LIMIT - 24'd2 + 24'($urandom_range(0, 4)));
            sel = $urandom_range(0, 9);
            rr  = (sel == 0) || (sel < 5);
            rw  = (sel == 0) || (sel >= 5);
            doTxn(ra, rr, rw, 2'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 999,
                  $sformatf("rand%0d", n));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
